memory_bus_interface: RTL and testbench
=======================================

MEMORY_BUS_INTERFACE -- requirements
Module: memory_bus_interface

Interface
REQ-001 Parameters SHALL be: WBUF_DEPTH, default 2, write-buffer entries (power of two, ≥2); TIMEOUT_CYCLES, default 255, max wait for mem_ack per transaction.
REQ-002 Ports SHALL be:
- clk  in  1  single system clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- cpu_addr_hi  in  8  CPU AddressBusHigh.
- cpu_addr_lo  in  8  CPU AddressBusLow.
- cpu_data_out  in  8  CPU dataBusOutput.
- cpu_read_not_write  in  1  1=read cycle, 0=write cycle.
- cpu_data_in  out  8  to CPU dataBusInput.
- cpu_ready  out  1  to CPU ready.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write transaction.
- mem_addr  out  16  {hi,lo}.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid with mem_ack.
- mem_ack  in  1  transaction complete.
- bus_error  out  1  sticky timeout flag.
- wbuf_overflow  out  1  sticky dropped-write flag.

Function
REQ-003 Every clk edge with cpu_read_not_write=0 SHALL be a CPU write; the CPU ignores ready on writes, so the block SHALL enqueue {addr,data} into the write buffer in that same cycle without stalling.
REQ-004 A write arriving while the buffer is full SHALL be dropped and SHALL set wbuf_overflow, unless a pop occurs in the same cycle, in which case the push SHALL succeed.
REQ-005 FSM states SHALL be IDLE, WRITE_WAIT, READ_WAIT, READ_DONE.
REQ-006 IDLE: buffer non-empty -> issue head write, go WRITE_WAIT; else cpu_read_not_write=1 -> capture address, issue read, go READ_WAIT; else stay.
REQ-007 Buffered writes SHALL always complete before any read issues (strict program order).
REQ-008 While in WRITE_WAIT/READ_WAIT, mem_req=1 with mem_addr/mem_we/mem_wdata stable until mem_ack is sampled 1; mem_req SHALL be 0 the cycle after the ack.
REQ-009 mem_ack while mem_req=0 SHALL be ignored.
REQ-010 WRITE_WAIT + ack: pop head, go IDLE.
REQ-011 READ_WAIT + ack: register mem_rdata into cpu_data_in, go READ_DONE.
REQ-012 cpu_ready SHALL be a registered output, 1 only in READ_DONE; READ_DONE SHALL last exactly one cycle then go IDLE.
REQ-013 Minimum read latency with immediate ack: issue cycle N, ack N+1, cpu_ready=1 in N+2.
REQ-014 cpu_data_in SHALL hold its last value outside READ_DONE.
REQ-015 Per-transaction cycle counter SHALL count cycles with mem_req=1; on reaching TIMEOUT_CYCLES without ack: set bus_error, drop mem_req; write: pop and discard; read: cpu_data_in=8'hFF, go READ_DONE.
REQ-016 Counter SHALL clear on each new issue; ack and timeout coinciding SHALL be treated as ack.
REQ-017 bus_error and wbuf_overflow SHALL clear only on reset.
REQ-018 Buffer pointers SHALL wrap modulo WBUF_DEPTH; occupancy counter width clog2(WBUF_DEPTH)+1.

Reset
REQ-019 nrst=0 SHALL immediately force: state IDLE, buffer empty, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_data_in=0, cpu_ready=0, bus_error=0, wbuf_overflow=0, counter=0.
REQ-020 Reset mid-transaction SHALL abandon it; a late mem_ack after release SHALL be ignored per REQ-009.

Structure
REQ-021 Package bus_if_pkg SHALL hold the FSM state enum, TIMEOUT data value 8'hFF, and default parameter constants.
REQ-022 Write buffer SHALL be a sub-module write_buffer_fifo (push, pop, full, empty, head data, 24-bit entries).

Verification
REQ-023 Read 0x1234, mem_ack 1 cycle after req with rdata 0xA9 -> mem_addr=0x1234, mem_we=0, cpu_ready=1 two cycles after issue with cpu_data_in=0xA9.
REQ-024 Writes 0x0200<-0x11, 0x0201<-0x22 then read 0x0200 -> mem sees W 0x0200/0x11, W 0x0201/0x22, then R 0x0200, in that order.
REQ-025 Three back-to-back writes with mem_ack held 0 (depth 2) -> third dropped, wbuf_overflow=1; first two reach memory once ack resumes.
REQ-026 Read 0x FFFC with no ack -> after 255 req cycles bus_error=1, cpu_ready=1, cpu_data_in=0xFF.
REQ-027 nrst pulsed low during READ_WAIT -> mem_req, cpu_ready, flags 0 immediately; a following ack is ignored.
REQ-028 Buffer full, write arrives in ack-pop cycle -> accepted, no overflow.

Source files
------------

// File: rtl/bus_if_pkg.sv
// Shared types and constants for the CPU-to-memory bus bridge.
// Holds the controller state encoding, write-buffer entry layout and defaults.
package bus_if_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_WAIT = 2'd1,
      READ_WAIT  = 2'd2,
      READ_DONE  = 2'd3
   } bus_state_e;

   localparam logic [7:0] TIMEOUT_DATA       = 8'hFF;
   localparam int         DEF_WBUF_DEPTH     = 2;
   localparam int         DEF_TIMEOUT_CYCLES = 255;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wbuf_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// Posted-write buffer: circular FIFO of {addr,data} entries.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module write_buffer_fifo
   import bus_if_pkg::*;
#(
   parameter int DEPTH = DEF_WBUF_DEPTH
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_push,
   input  wbuf_entry_t i_data,
   input  logic        i_pop,
   output logic        o_full,
   output logic        o_empty,
   output wbuf_entry_t o_head
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

   wbuf_entry_t   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/memory_bus_interface.sv
// Bridges an 8-bit CPU bus to a req/ack memory port. Writes are posted into a
// buffer and drained ahead of any read; every transaction is bounded by a timeout.
module memory_bus_interface
   import bus_if_pkg::*;
#(
   parameter int WBUF_DEPTH     = DEF_WBUF_DEPTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [7:0]  cpu_addr_hi,
   input  logic [7:0]  cpu_addr_lo,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_read_not_write,
   output logic [7:0]  cpu_data_in,
   output logic        cpu_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        bus_error,
   output logic        wbuf_overflow
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   bus_state_e   r_state;
   logic [CW-1:0] r_cnt;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic         w_ack;
   logic         w_tmo;
   wbuf_entry_t  w_wentry;
   wbuf_entry_t  w_head;

   assign w_push   = !cpu_read_not_write;
   assign w_wentry = '{addr: {cpu_addr_hi, cpu_addr_lo}, data: cpu_data_out};
   assign w_ack    = mem_ack && mem_req;
   // r_cnt holds the number of earlier req cycles, so this is the last allowed one.
   assign w_tmo    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_pop    = (r_state == WRITE_WAIT) && (w_ack || w_tmo);

   write_buffer_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk     (clk),
      .nrst    (nrst),
      .i_push  (w_push),
      .i_data  (w_wentry),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         cpu_data_in   <= '0;
         cpu_ready     <= 1'b0;
         bus_error     <= 1'b0;
         wbuf_overflow <= 1'b0;
      end else begin
         if (w_push && w_full && !w_pop) wbuf_overflow <= 1'b1;

         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (!w_empty) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= w_head.addr;
                  mem_wdata <= w_head.data;
                  r_state   <= WRITE_WAIT;
               end else if (cpu_read_not_write) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {cpu_addr_hi, cpu_addr_lo};
                  r_state  <= READ_WAIT;
               end
            end

            WRITE_WAIT, READ_WAIT: begin
               // An ack landing on the timeout cycle wins over the timeout.
               if (w_ack || w_tmo) begin
                  mem_req <= 1'b0;
                  if (!w_ack) bus_error <= 1'b1;
                  if (r_state == READ_WAIT) begin
                     cpu_data_in <= w_ack ? mem_rdata : TIMEOUT_DATA;
                     cpu_ready   <= 1'b1;
                     r_state     <= READ_DONE;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            READ_DONE: begin
               cpu_ready <= 1'b0;
               r_state   <= IDLE;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_bus_interface.sv
// Bench for memory_bus_interface: a CPU driver, a req/ack memory responder with a
// transaction scoreboard, a table of read vectors and hand-built corner sequences.
module tb_memory_bus_interface;
   import bus_if_pkg::*;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [7:0]  cpu_addr_hi = '0;
   logic [7:0]  cpu_addr_lo = '0;
   logic [7:0]  cpu_data_out = '0;
   logic        cpu_read_not_write = 1'b1;
   logic [7:0]  cpu_data_in;
   logic        cpu_ready;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        bus_error;
   logic        wbuf_overflow;

   memory_bus_interface dut (
      .clk                (clk),
      .nrst               (nrst),
      .cpu_addr_hi        (cpu_addr_hi),
      .cpu_addr_lo        (cpu_addr_lo),
      .cpu_data_out       (cpu_data_out),
      .cpu_read_not_write (cpu_read_not_write),
      .cpu_data_in        (cpu_data_in),
      .cpu_ready          (cpu_ready),
      .mem_req            (mem_req),
      .mem_we             (mem_we),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_rdata          (mem_rdata),
      .mem_ack            (mem_ack),
      .bus_error          (bus_error),
      .wbuf_overflow      (wbuf_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } txn_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  rdata;
      int          delay;
      logic [7:0]  exp_data;
      int          exp_lat;
   } rd_vec_t;

   txn_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_dout = '0;

   int         ack_delay = 1;
   bit         drop_writes = 1'b0;
   bit         stray_pending = 1'b0;
   logic [7:0] rd_val = '0;
   int         m_cnt = 0;
   int         cur_len = 0;
   int         last_len = 0;
   txn_t       m_cur;
   txn_t       m_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Memory responder: logs each new transaction against the scoreboard, checks the
   // request stays stable, and acks after ack_delay request cycles.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (!nrst || !mem_req) begin
            if (cur_len > 0) last_len = cur_len;
            m_cnt   = 0;
            cur_len = 0;
         end else begin
            if (m_cnt == 0) begin
               m_cur = {mem_we, mem_addr, mem_wdata};
               chk("sb_pending", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  m_exp = exp_q.pop_front();
                  chk("txn_we", mem_we, m_exp.we);
                  chk("txn_addr", mem_addr, m_exp.addr);
                  if (m_exp.we) chk("txn_wdata", mem_wdata, m_exp.data);
               end
            end else begin
               chk("req_stable", {mem_we, mem_addr, mem_wdata}, m_cur);
            end
            m_cnt++;
            cur_len++;
            if (m_cnt > ack_delay && !(drop_writes && mem_we)) begin
               mem_ack   = 1'b1;
               mem_rdata = rd_val;
            end
         end
         if (stray_pending) begin
            mem_ack       = 1'b1;
            stray_pending = 1'b0;
         end
      end
   end

   task automatic do_reset();
      nrst = 1'b0;
      cpu_read_not_write = 1'b1;
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      exp_dout = '0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit reaches_mem);
      {cpu_addr_hi, cpu_addr_lo} = a;
      cpu_data_out       = d;
      cpu_read_not_write = 1'b0;
      if (reaches_mem) exp_q.push_back({1'b1, a, d});
      @(posedge clk); #1;
   endtask

   task automatic cpu_read(input logic [15:0] a, input logic [7:0] d, input int budget,
                           input int exp_lat, input string nm);
      int lat;
      bit got;
      {cpu_addr_hi, cpu_addr_lo} = a;
      cpu_read_not_write = 1'b1;
      exp_q.push_back({1'b0, a, 8'h00});
      lat = 0;
      got = 1'b0;
      while (!got && lat < budget) begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk({nm, "_hold"}, cpu_data_in, exp_dout);
         got = cpu_ready;
      end
      chk({nm, "_ready"}, got, 1);
      if (got) begin
         chk({nm, "_data"}, cpu_data_in, d);
         if (exp_lat > 0) chk({nm, "_lat"}, lat, exp_lat);
         exp_dout = d;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rd_vec_t vecs[4];
      // ready appears on the (delay+3)th negedge after the read is presented
      vecs[0] = '{16'h1234, 8'hA9, 1, 8'hA9, 4};
      vecs[1] = '{16'h0000, 8'h00, 0, 8'h00, 3};
      vecs[2] = '{16'hFFFF, 8'h5A, 3, 8'h5A, 6};
      vecs[3] = '{16'h8001, 8'hC3, 2, 8'hC3, 5};

      do_reset();
      chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
      chk("rst_ctrl", {mem_req, mem_we, cpu_data_in, cpu_ready, bus_error, wbuf_overflow}, 0);

      foreach (vecs[i]) begin
         ack_delay = vecs[i].delay;
         rd_val    = vecs[i].rdata;
         cpu_read(vecs[i].addr, vecs[i].exp_data, 20, vecs[i].exp_lat, $sformatf("rd%0d", i));
      end

      // posted writes drain in order ahead of the read
      ack_delay = 1;
      rd_val    = 8'h77;
      cpu_write(16'h0200, 8'h11, 1'b1);
      cpu_write(16'h0201, 8'h22, 1'b1);
      cpu_read(16'h0200, 8'h77, 30, -1, "order_rd");
      chk("order_drained", exp_q.size(), 0);

      // full buffer, push lands in the ack/pop cycle
      ack_delay = 0;
      rd_val    = 8'h3C;
      cpu_write(16'h0210, 8'hA1, 1'b1);
      cpu_write(16'h0211, 8'hA2, 1'b1);
      cpu_write(16'h0212, 8'hA3, 1'b1);
      chk("popcycle_no_ovf", wbuf_overflow, 0);
      cpu_read(16'h0210, 8'h3C, 30, -1, "popcycle_rd");
      chk("popcycle_no_ovf2", wbuf_overflow, 0);

      // read with no ack times out after exactly TIMEOUT_CYCLES request cycles
      ack_delay = 1000;
      chk("tmo_err_before", bus_error, 0);
      cpu_read(16'hFFFC, TIMEOUT_DATA, 300, 257, "tmo_rd");
      chk("tmo_err_after", bus_error, 1);
      chk("tmo_req_len", last_len, 255);

      do_reset();
      chk("rst_clears_err", {bus_error, wbuf_overflow}, 0);

      // three writes while the first is unacked: the third is dropped
      ack_delay = 4;
      rd_val    = 8'h44;
      cpu_write(16'h0300, 8'h11, 1'b1);
      cpu_write(16'h0301, 8'h22, 1'b1);
      chk("ovf_before", wbuf_overflow, 0);
      cpu_write(16'h0302, 8'h33, 1'b0);
      chk("ovf_set", wbuf_overflow, 1);
      cpu_read(16'h0300, 8'h44, 40, -1, "ovf_rd");
      chk("ovf_sticky", wbuf_overflow, 1);

      // unacked write is discarded on timeout and the read behind it proceeds
      chk("wtmo_err_before", bus_error, 0);
      drop_writes = 1'b1;
      ack_delay   = 1;
      rd_val      = 8'h66;
      cpu_write(16'h0400, 8'h55, 1'b1);
      cpu_read(16'h0401, 8'h66, 400, -1, "wtmo_rd");
      chk("wtmo_err_after", bus_error, 1);
      drop_writes = 1'b0;

      // reset pulsed in the middle of a read wait
      ack_delay = 1000;
      {cpu_addr_hi, cpu_addr_lo} = 16'h4000;
      cpu_read_not_write = 1'b1;
      exp_q.push_back({1'b0, 16'h4000, 8'h00});
      repeat (4) @(posedge clk);
      #1;
      chk("midrd_state", {mem_req, bus_error, wbuf_overflow}, 3'b111);
      nrst = 1'b0;
      #1;
      chk("midrd_async_rst", {mem_req, cpu_ready, bus_error, wbuf_overflow, mem_addr}, 0);
      ack_delay     = 2;
      rd_val        = 8'h99;
      stray_pending = 1'b1;
      @(posedge clk); #1;
      nrst     = 1'b1;
      exp_dout = '0;
      cpu_read(16'h4001, 8'h99, 20, 5, "post_rst_rd");
      chk("post_rst_flags", {bus_error, wbuf_overflow}, 0);

      chk("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
